// File: rtl/sha512_pkg.sv
// Shared SHA-512 definitions: round constants, standard IVs and the FIPS 180-4 bit functions.
package sha512_pkg;

   localparam int ROUNDS = 80;
   localparam int WORD_W = 64;
   localparam int CNT_W  = 7;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [WORD_W-1:0] K [0:ROUNDS-1] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   // Initial hash values, packed H0 in the top word as on i_vin.
   localparam logic [511:0] IV_SHA512 = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
   localparam logic [511:0] IV_SHA384 = {
      64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
      64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
   localparam logic [511:0] IV_SHA512_224 = {
      64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
      64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
   localparam logic [511:0] IV_SHA512_256 = {
      64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
      64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [63:0] big_sigma0(input logic [63:0] x);
      return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
   endfunction

   function automatic logic [63:0] big_sigma1(input logic [63:0] x);
      return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
   endfunction

   function automatic logic [63:0] small_sigma0(input logic [63:0] x);
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
   endfunction

   function automatic logic [63:0] small_sigma1(input logic [63:0] x);
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
   endfunction

   function automatic logic [63:0] ch(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [63:0] maj(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha512_msg_sched.sv
// SHA-512 message schedule: 16-word window whose head is W[t]; the tail is refilled with W[t+16].
module sha512_msg_sched
   import sha512_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_load,
   input  logic          i_shift,
   input  logic [1023:0] i_data,
   output logic [63:0]   o_w
);

   logic [63:0] w [0:15];

   // Pure datapath: contents are only meaningful after a load, so no reset.
   always_ff @(posedge i_clk) begin
      if (i_load) begin
         for (int i = 0; i < 16; i++) w[i] <= i_data[1023-64*i -: 64];
      end else if (i_shift) begin
         for (int i = 0; i < 15; i++) w[i] <= w[i+1];
         w[15] <= small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
      end
   end

   assign o_w = w[0];

endmodule

// File: rtl/sha512_hash_core.sv
// Single-block SHA-512 compression: 80 rounds, one per cycle, then a feed-forward cycle.
// Optional o_busy output is enabled by defining SHA512_CORE_BUSY_EN.
module sha512_hash_core
   import sha512_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [1023:0] i_data,
   input  logic [511:0]  i_vin,
   output logic [511:0]  o_vout,
`ifdef SHA512_CORE_BUSY_EN
   output logic          o_busy,
`endif
   output logic          o_done
);

   state_t           state;
   logic [CNT_W-1:0] t;
   logic [63:0]      hv [0:7];
   logic [63:0]      wv [0:7];
   logic [63:0]      w_t, k_t, t1, t2;
   logic             last_rnd;

   assign last_rnd = (t == CNT_W'(ROUNDS));

   sha512_msg_sched u_sched (
      .i_clk   (i_clk),
      .i_load  (state == S_IDLE && i_start),
      .i_shift (state == S_RUN && !last_rnd),
      .i_data  (i_data),
      .o_w     (w_t)
   );

   always_comb begin
      k_t = '0;
      if (!last_rnd) k_t = K[t];
      t1 = wv[7] + big_sigma1(wv[4]) + ch(wv[4], wv[5], wv[6]) + k_t + w_t;
      t2 = big_sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);
   end

   // t counts 0..79 for the rounds; t==80 is the feed-forward/done edge.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state  <= S_IDLE;
         t      <= '0;
         o_done <= 1'b0;
         o_vout <= '0;
         for (int i = 0; i < 8; i++) begin
            hv[i] <= '0;
            wv[i] <= '0;
         end
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  for (int i = 0; i < 8; i++) begin
                     hv[i] <= i_vin[511-64*i -: 64];
                     wv[i] <= i_vin[511-64*i -: 64];
                  end
                  t     <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (last_rnd) begin
                  for (int i = 0; i < 8; i++) o_vout[511-64*i -: 64] <= hv[i] + wv[i];
                  o_done <= 1'b1;
                  t      <= '0;
                  state  <= S_IDLE;
               end else begin
                  wv[0] <= t1 + t2;
                  wv[1] <= wv[0];
                  wv[2] <= wv[1];
                  wv[3] <= wv[2];
                  wv[4] <= wv[3] + t1;
                  wv[5] <= wv[4];
                  wv[6] <= wv[5];
                  wv[7] <= wv[6];
                  t     <= t + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SHA512_CORE_BUSY_EN
   // High through the done cycle; a start taken during that cycle keeps it high.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)                o_busy <= 1'b0;
      else if (state == S_IDLE)  o_busy <= i_start;
      else                       o_busy <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_sha512_hash_core.sv
// Scoreboard bench for sha512_hash_core: known-answer vectors plus random blocks against an array-based SHA-512 model.
module tb_sha512_hash_core;
   import sha512_pkg::*;

   logic          r_clk;
   logic          r_rst_n;
   logic          i_start;
   logic [1023:0] i_data;
   logic [511:0]  i_vin;
   logic [511:0]  o_vout;
   logic          o_done;
`ifdef SHA512_CORE_BUSY_EN
   logic          o_busy;
`endif

   sha512_hash_core dut (
      .i_clk   (r_clk),
      .i_rst   (r_rst_n),
      .i_start (i_start),
      .i_data  (i_data),
      .i_vin   (i_vin),
      .o_vout  (o_vout),
`ifdef SHA512_CORE_BUSY_EN
      .o_busy  (o_busy),
`endif
      .o_done  (o_done)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   typedef struct {
      string        name;
      logic [511:0] exp;
      logic [511:0] mask;
   } exp_t;

   exp_t exp_q [$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_pushed = 0;
   int   n_dones  = 0;

   localparam logic [511:0] FULL_MASK = '1;
   localparam logic [511:0] TOP224    = {{224{1'b1}}, 288'b0};

   // ---------------- reference model ----------------
   function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [511:0] ref_compress(input logic [1023:0] blk, input logic [511:0] v);
      logic [63:0] w [80];
      logic [63:0] s [8];
      logic [63:0] x1, x2, s0, s1;
      logic [511:0] r;
      for (int i = 0; i < 16; i++) w[i] = blk[1023-64*i -: 64];
      for (int i = 16; i < 80; i++) begin
         s0 = m_rotr(w[i-15], 1) ^ m_rotr(w[i-15], 8) ^ (w[i-15] >> 7);
         s1 = m_rotr(w[i-2], 19) ^ m_rotr(w[i-2], 61) ^ (w[i-2] >> 6);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      for (int i = 0; i < 8; i++) s[i] = v[511-64*i -: 64];
      for (int j = 0; j < 80; j++) begin
         x1 = s[7] + (m_rotr(s[4], 14) ^ m_rotr(s[4], 18) ^ m_rotr(s[4], 41))
              + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[j] + w[j];
         x2 = (m_rotr(s[0], 28) ^ m_rotr(s[0], 34) ^ m_rotr(s[0], 39))
              + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
         for (int i = 7; i > 0; i--) s[i] = s[i-1];
         s[4] = s[4] + x1;
         s[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) r[511-64*i -: 64] = v[511-64*i -: 64] + s[i];
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input string nm, input logic [511:0] e, input logic [511:0] m);
      exp_t x;
      x.name = nm; x.exp = e; x.mask = m;
      exp_q.push_back(x);
      n_pushed++;
   endtask

   // Called at #1 after a posedge; the next posedge is the start edge E0.
   task automatic start_block(input logic [1023:0] blk, input logic [511:0] vin);
      i_data = blk; i_vin = vin; i_start = 1'b1;
      @(posedge r_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!o_done && cycles < 200) begin
         @(posedge r_clk); #1;
         cycles++;
      end
   endtask

   function automatic logic [1023:0] rand_block();
      logic [1023:0] b;
      for (int j = 0; j < 32; j++) b[32*j +: 32] = $urandom;
      return b;
   endfunction

   function automatic logic [511:0] rand_vin();
      logic [511:0] v;
      for (int j = 0; j < 16; j++) v[32*j +: 32] = $urandom;
      return v;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge r_clk) begin
      if (r_rst_n && o_done) begin
         exp_t e;
         n_dones++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_done: got o_vout %h required no completion", o_vout);
         end else begin
            e = exp_q.pop_front();
            if ((o_vout & e.mask) !== (e.exp & e.mask)) begin
               n_errors++;
               $display("FAIL %s: got %h required %h", e.name, o_vout & e.mask, e.exp & e.mask);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [1023:0] abc, blk1, blk2, blk_a, blk_b;
      logic [511:0]  v, vprev;
      int            cyc;

      abc = '0;
      abc[1023:992] = 32'h61626380;
      abc[63:0]     = 64'h18;
      blk1 = '0;
      blk2 = '0;
      for (int i = 0; i < 128; i++) blk1[1023-8*i -: 8] = 8'h30 + 8'((i + 1) % 10);
      for (int i = 128; i < 160; i++) blk2[1023-8*(i-128) -: 8] = 8'h30 + 8'((i + 1) % 10);
      blk2[1023-8*32 -: 8] = 8'h80;
      blk2[63:0] = 64'h500;

      r_rst_n = 1'b0; i_start = 1'b0; i_data = '0; i_vin = '0;
      repeat (3) @(posedge r_clk);
      #1;
      chk("reset_vout", o_vout, '0);
      chk("reset_done", 512'(o_done), '0);
      r_rst_n = 1'b1;
      @(posedge r_clk); #1;

      // SHA-512 "abc", latency and pulse shape
      push_exp("sha512_abc", 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f, FULL_MASK);
      start_block(abc, IV_SHA512);
      wait_done(cyc);
      chk("abc_latency", 512'(cyc), 512'd81);
`ifdef SHA512_CORE_BUSY_EN
      chk("busy_in_done", 512'(o_busy), 512'd1);
`endif
      v = o_vout;
      @(posedge r_clk); #1;
      chk("done_width", 512'(o_done), '0);
`ifdef SHA512_CORE_BUSY_EN
      chk("busy_after", 512'(o_busy), '0);
`endif
      repeat (4) @(posedge r_clk);
      #1;
      chk("vout_stable", o_vout, v);

      // SHA-512/224 "abc"
      push_exp("sha512_224_abc", {224'h4634270f707b6a54daae7530460842e20e37ed265ceee9a43e8924aa, 288'b0}, TOP224);
      start_block(abc, IV_SHA512_224);
      wait_done(cyc);
      chk("abc224_latency", 512'(cyc), 512'd81);

      // Two-block chain, second start issued in the done cycle
      push_exp("chain_blk1", ref_compress(blk1, IV_SHA512_224), FULL_MASK);
      start_block(blk1, IV_SHA512_224);
      wait_done(cyc);
      chk("chain1_latency", 512'(cyc), 512'd81);
      push_exp("chain_final", {224'h1a7dd4c3e52b058792188abf37076bc51685a3bfa5558dad19227274, 288'b0}, TOP224);
      start_block(blk2, o_vout);
      wait_done(cyc);
      chk("chain2_latency", 512'(cyc), 512'd81);
      repeat (3) @(posedge r_clk);
      #1;

      // Start pulse during round 40 must be ignored
      blk_a = rand_block();
      blk_b = rand_block();
      v = rand_vin();
      push_exp("busy_start", ref_compress(blk_a, v), FULL_MASK);
      start_block(blk_a, v);
      repeat (40) @(posedge r_clk);
      #1;
      start_block(blk_b, rand_vin());
      wait_done(cyc);
      chk("busy_start_latency", 512'(cyc), 512'd40);
      repeat (100) @(posedge r_clk);
      #1;
      chk("busy_start_one_done", 512'(n_dones), 512'(n_pushed));

      // Reset at round 20 aborts the block
      start_block(abc, IV_SHA384);
      repeat (20) @(posedge r_clk);
      #1;
      r_rst_n = 1'b0;
      #2;
      chk("abort_vout", o_vout, '0);
      chk("abort_done", 512'(o_done), '0);
      @(posedge r_clk); #1;
      r_rst_n = 1'b1;
      @(posedge r_clk); #1;
      push_exp("abc_after_reset", 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f, FULL_MASK);
      start_block(abc, IV_SHA512);
      wait_done(cyc);
      chk("post_reset_latency", 512'(cyc), 512'd81);

      // Random back-to-back blocks, chaining every other one
      vprev = IV_SHA512_256;
      for (int n = 0; n < 8; n++) begin
         blk_a = rand_block();
         v = (n % 2 == 1) ? vprev : rand_vin();
         vprev = ref_compress(blk_a, v);
         push_exp($sformatf("rand_%0d", n), vprev, FULL_MASK);
         start_block(blk_a, v);
         wait_done(cyc);
         chk($sformatf("rand_%0d_latency", n), 512'(cyc), 512'd81);
      end

      repeat (5) @(posedge r_clk);
      #1;
      chk("queue_drained", 512'(exp_q.size()), '0);
      chk("done_count", 512'(n_dones), 512'(n_pushed));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
